// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the cpu data-memory bus.
// Firmware stores bytes to TXDATA. They queue in a small FIFO and are
// serialised LSB first on tx, so debug output never stalls the processor.
// The block runs on the free-running clk.
//
// Register window at BASE_ADDR (word-aligned, 8 bytes):
//   +0 TXDATA  W: push write_data[7:0]; R: 0
//   +4 STATUS  R: {28'b0, ovf, active, empty, full}; W: bit3=1 clears ovf
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   addr        cpu data-memory address
//   write_data  cpu store data
//   memwrite    store strobe
//   memread     load strobe
//   read_data   load data (combinational)
//   tx          serial line, idle high, registered
//   busy        FIFO non-empty or a frame in flight
module uart_tx_mmio #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned DIV       = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W     = $clog2(DIV);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W     = AW + 1;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic sel_data_c, sel_stat_c;
  logic full_c, empty_c, push_c, pop_c, active_c;
  logic unused_wdata_c;

  // Exact-match decode; BASE_ADDR is word-aligned, so unaligned addresses never select.
  assign sel_data_c = (addr == BASE_ADDR);
  assign sel_stat_c = (addr == STAT_ADDR);

  assign unused_wdata_c = ^write_data[31:8];

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_c  = (wptr_q == rptr_q);
  assign full_c   = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_c   = memwrite && sel_data_c && !full_c;
  assign active_c = (state_q != S_IDLE);

  // Bus read mux; zero unless a load hits STATUS.
  always_comb begin
    read_data = 32'b0;
    if (memread && sel_stat_c) begin
      read_data = {28'b0, ovf_q, active_c, empty_c, full_c};
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q[AW-1:0]] <= write_data[7:0];
    end
  end

  // Serialiser next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rptr_q[AW-1:0]];
          state_d = S_START;
          tx_d    = 1'b0;
          cnt_d   = CNT_W'(DIV - 1);
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          cnt_d   = CNT_W'(DIV - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(DIV - 1);
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rptr_q[AW-1:0]];
            state_d = S_START;
            tx_d    = 1'b0;
            cnt_d   = CNT_W'(DIV - 1);
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Pointer, sticky overflow and busy next-state.
  always_comb begin
    wptr_d = wptr_q + PTR_W'(push_c);
    rptr_d = rptr_q + PTR_W'(pop_c);
    ovf_d  = ovf_q;
    if (memwrite && sel_stat_c && write_data[3]) begin
      ovf_d = 1'b0;
    end
    // An overflowing push wins over a clear on the same edge.
    if (memwrite && sel_data_c && full_c) begin
      ovf_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE) || (wptr_d != rptr_d);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped 8N1 UART transmitter on the cpu's data-memory bus, alongside data_mem.
- Decodes its own address window from the cpu's data-memory address, write-data, write and read strobes.
- Buffers bytes in a small FIFO and serialises them on a single TX pin.
- Lets firmware print debug output without stalling the processor clock.

Parameters:
- CLK_HZ, 12000000, frequency of clk (HFOSC divided to 12 MHz).
- BAUD, 115200, line rate. DIV = round(CLK_HZ/BAUD) = 104 clk cycles per bit.
- BASE_ADDR, 32'h0000_2000, word-aligned base of the 8-byte register window.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  data-memory address from the cpu.
- write_data  input  32  store data from the cpu.
- memwrite  input  1  store strobe.
- memread  input  1  load strobe.
- read_data  output  32  load data; combinational.
- tx  output  1  serial line; idle high.
- busy  output  1  high while FIFO is non-empty or a frame is in flight.

Behaviour:
- Decode:
  - sel_data = (addr == BASE_ADDR).
  - sel_stat = (addr == BASE_ADDR+4).
  - addr[1:0] must be 0; any other address is ignored.
- TXDATA write (memwrite && sel_data, sampled at the clk edge):
  - Pushes write_data[7:0] into the FIFO.
  - If the FIFO is full before that edge, the byte is dropped and sticky ovf is set.
  - A pop on the same edge does not rescue a push while full.
- STATUS read (memread && sel_stat): read_data = {28'b0, ovf, active, empty, full}.
- TXDATA read: returns 0.
- Any read with memread low or with no select active returns 32'b0.
- STATUS write: write_data[3]=1 clears ovf; all other bits are ignored.
- If a push overflows on the same edge as an ovf clear, the set wins.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers.
  - full when pointers differ only in the MSB; empty when the pointers are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty at an edge, pop into shift register, go to START, load baud counter with DIV-1.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] (LSB first). Each bit lasts DIV cycles; shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for DIV cycles. At the end, if !empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - A write at edge N into an empty FIFO with the FSM in IDLE → tx falls at edge N+1.
  - Frame = 10*DIV cycles = 1040 cycles.
- active = (state != IDLE). busy = active | !empty.
- tx is registered; no glitches.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, tx=1, busy=0, ovf=0.
  - FIFO pointers=0; counters=0.
  - read_data follows the combinational rule (0 unless a valid read is decoded).
- Writes and reads outside the window have no effect.
- read_data must not depend on the clock-stall logic. The block runs on the free-running clk, not the stalled processor clock.

Test Plan:
- Reset then idle: tx=1, busy=0. STATUS read returns 32'h2 (empty only).
- Single byte: write 32'hA5 to 0x2000 at edge N.
  - tx=0 on cycles N+1..N+104.
  - Then bits 1,0,1,0,0,1,0,1, each 104 cycles.
  - Stop high for 104 cycles.
  - busy falls at cycle N+1041.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles. The second start bit begins exactly 1040 cycles after the first, with no idle gap.
- Overflow: write 9 bytes while the first frame is in flight.
  - 9th byte is accepted (one entry was already popped).
  - 10th write sets STATUS bit3 and its byte never appears on tx.
  - Write 32'h8 to 0x2004 to clear bit3.
- Full boundary: with the FSM held in a frame and 8 bytes queued, STATUS reads 32'h5 (full, active). After one pop it reads 32'h4.
- Mid-frame reset: assert reset during DATA bit 3.
  - tx=1 immediately (asynchronous); FIFO empty.
  - After release, no further frame is emitted until a new write.
